// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU instruction-memory loader.
// Holds the loader state encoding and the instruction-memory constants.
package cpu_pkg;

  localparam int          IMEM_WORDS = 1024;
  localparam logic [15:0] HALT_INSTR = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HIGH  = 3'd1,
    LOW   = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4,
    ERROR = 3'd5
  } loader_state_t;

  // Byte intake is only open while a word is being assembled.
  function automatic logic accepts_bytes(input loader_state_t s);
    return (s == HIGH) || (s == LOW);
  endfunction

endpackage

// File: rtl/byte_pair_packer.sv
// Latches the high and low byte of an instruction word; word_o = {hi, lo}.
// One-cycle load per byte, no backpressure of its own (enables come from the FSM).
module byte_pair_packer (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        hi_en_i,
  input  logic        lo_en_i,
  input  logic [7:0]  byte_i,
  output logic [15:0] word_o
);

  logic [7:0] hi_q, hi_d;
  logic [7:0] lo_q, lo_d;

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (hi_en_i) hi_d = byte_i;
    if (lo_en_i) lo_d = byte_i;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hi_q <= 8'h00;
      lo_q <= 8'h00;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign word_o = {hi_q, lo_q};

endmodule

// File: rtl/imem_loader.sv
// Packs a byte stream into 16-bit words and writes them to instruction memory until the halt word.
// Write strobe one cycle after the low-byte transfer; in_ready decoded from state (2 bytes / 3 cycles).
module imem_loader
  import cpu_pkg::*;
#(
  parameter int          DEPTH     = IMEM_WORDS,
  parameter int          ADDR_W    = 10,
  parameter logic [15:0] HALT_WORD = HALT_INSTR
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              cpu_run,
  output logic              error
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              xfer;
  logic [15:0]       word;

  assign xfer = in_valid && in_ready;

  byte_pair_packer u_packer (
    .clock   (clock),
    .reset_n (reset_n),
    .hi_en_i (xfer && (state_q == HIGH)),
    .lo_en_i (xfer && (state_q == LOW)),
    .byte_i  (in_data),
    .word_o  (word)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          addr_d  = '0;
          count_d = '0;
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (xfer) state_d = LOW;
      end
      LOW: begin
        if (xfer) state_d = WRITE;
      end
      WRITE: begin
        count_d = count_q + 1'b1;
        // A halt word in the last slot still counts as a successful load.
        if (word == HALT_WORD) begin
          state_d = DONE;
        end else if (addr_q == LAST_ADDR) begin
          state_d = ERROR;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = HIGH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
    end
  end

  assign in_ready   = accepts_bytes(state_q);
  assign mem_we     = (state_q == WRITE);
  assign mem_addr   = addr_q;
  assign mem_wdata  = word;
  assign word_count = count_q;
  assign cpu_run    = (state_q == DONE);
  assign error      = (state_q == ERROR);

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader (DEPTH=4): directed loads plus random streams against a word-list model.
module tb_imem_loader;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clock    = 1'b0;
  logic          reset_n  = 1'b0;
  logic          start    = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data  = 8'h00;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic [AW:0]   word_count;
  logic          cpu_run;
  logic          error;

  always #5 clock = ~clock;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(AW), .HALT_WORD(16'hFFFF)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .word_count (word_count),
    .cpu_run    (cpu_run),
    .error      (error)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Observed write log, sampled mid-cycle.
  logic [AW-1:0] wa_q[$];
  logic [15:0]   wd_q[$];
  int            wc_q[$];
  int            we_double = 0;
  int            run_cyc   = -1;
  logic          prev_we   = 1'b0;
  logic          prev_run  = 1'b0;

  always @(negedge clock) begin
    if (mem_we) begin
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_wdata);
      wc_q.push_back(cyc);
      if (prev_we) we_double++;
    end
    if (cpu_run && !prev_run) run_cyc = cyc;
    prev_we  = mem_we;
    prev_run = cpu_run;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [7:0] stim_b[$];
  int         stim_gap[$];

  task automatic push_word(input logic [15:0] w);
    stim_b.push_back(w[15:8]);
    stim_b.push_back(w[7:0]);
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    wc_q.delete();
    we_double = 0;
    run_cyc   = -1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_rdy"},   in_ready,   0);
    check_eq({tag, "_we"},    mem_we,     0);
    check_eq({tag, "_addr"},  mem_addr,   0);
    check_eq({tag, "_wdata"}, mem_wdata,  0);
    check_eq({tag, "_count"}, word_count, 0);
    check_eq({tag, "_run"},   cpu_run,    0);
    check_eq({tag, "_err"},   error,      0);
  endtask

  // Called and returns at a negedge; the byte transfers on the posedge in between.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit rdy_in_gap,
                           input bit poke_start, output bit ok);
    int n;
    ok = 1'b1;
    for (int i = 0; i < gap; i++) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      if (rdy_in_gap) check_eq("stall_rdy", in_ready, 1);
      @(negedge clock);
    end
    in_valid = 1'b1;
    in_data  = b;
    start    = poke_start;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clock);
      start = 1'b0;
      n++;
    end
    if (!in_ready) begin
      check_eq("rdy_timeout", in_ready, 1);
      ok       = 1'b0;
      in_valid = 1'b0;
      start    = 1'b0;
      return;
    end
    @(negedge clock);
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic run_load(input string tag, input bit full_rate, input bit stall_chk, input bit poke);
    logic [15:0]   exp_d[$];
    logic [AW-1:0] exp_a[$];
    logic [15:0]   ew;
    bit            halted;
    bit            ok;
    int            s_cyc;
    int            gap;
    int            n;
    clear_log();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    s_cyc = cyc;
    check_eq({tag, "_start_run"}, cpu_run, 0);
    check_eq({tag, "_start_err"}, error, 0);
    check_eq({tag, "_start_rdy"}, in_ready, 1);
    for (int i = 0; i < stim_b.size(); i++) begin
      if (full_rate)      gap = 0;
      else if (stall_chk) gap = stim_gap[i];
      else                gap = $urandom_range(0, 3);
      send_byte(stim_b[i], gap, stall_chk, poke && (i > 0) && ($urandom_range(0, 3) == 0), ok);
      if (!ok) break;
    end
    repeat (4) @(negedge clock);

    // Model: consecutive byte pairs become words at 0,1,2..; stop at halt or when memory is full.
    halted = 1'b0;
    for (int w = 0; 2 * w + 1 < stim_b.size(); w++) begin
      ew = {stim_b[2*w], stim_b[2*w+1]};
      exp_d.push_back(ew);
      exp_a.push_back(AW'(w));
      if (ew == 16'hFFFF) begin
        halted = 1'b1;
        break;
      end
      if (w == DEPTH - 1) break;
    end

    check_eq({tag, "_nwrites"}, wd_q.size(), exp_d.size());
    n = (wd_q.size() < exp_d.size()) ? wd_q.size() : exp_d.size();
    for (int i = 0; i < n; i++) begin
      check_eq({tag, "_addr"}, wa_q[i], exp_a[i]);
      check_eq({tag, "_data"}, wd_q[i], exp_d[i]);
    end
    check_eq({tag, "_count"}, word_count, exp_d.size());
    check_eq({tag, "_run"},   cpu_run, halted);
    check_eq({tag, "_err"},   error, !halted);
    check_eq({tag, "_rdy_end"}, in_ready, 0);
    check_eq({tag, "_we_end"},  mem_we, 0);
    check_eq({tag, "_we_1cyc"}, we_double, 0);
    if (full_rate && n > 0) begin
      check_eq({tag, "_lat"}, wc_q[0] - s_cyc, 2);
      for (int i = 1; i < n; i++) check_eq({tag, "_spacing"}, wc_q[i] - wc_q[i-1], 3);
      if (halted) check_eq({tag, "_run_lat"}, run_cyc - wc_q[n-1], 1);
    end
  endtask

  initial begin
    int r;
    logic [15:0] w;

    repeat (2) @(negedge clock);
    check_reset_outputs("rst");
    reset_n = 1'b1;
    @(negedge clock);

    // Idle without start: bytes on offer are not taken.
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (3) @(negedge clock);
    check_eq("idle_rdy", in_ready, 0);
    check_eq("idle_nwrites", wd_q.size(), 0);
    in_valid = 1'b0;

    stim_b = '{8'h71, 8'h0F, 8'h72, 8'h07, 8'hFF, 8'hFF};
    run_load("basic", 1'b1, 1'b0, 1'b0);

    stim_b = '{8'h12, 8'h34, 8'hFF, 8'hFF};
    run_load("restart", 1'b1, 1'b0, 1'b0);

    stim_b = '{8'hFF, 8'h00, 8'hFF, 8'hFF};
    run_load("nearhalt", 1'b1, 1'b0, 1'b0);

    stim_b   = '{8'h26, 8'hC0, 8'hFF, 8'hFF};
    stim_gap = '{0, 5, 0, 0};
    run_load("stall", 1'b0, 1'b1, 1'b0);

    stim_b = '{8'h00, 8'h00, 8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33};
    run_load("overflow", 1'b1, 1'b0, 1'b0);

    stim_b = '{8'hAA, 8'hFF, 8'hFF, 8'hFF};
    run_load("from_err", 1'b1, 1'b0, 1'b0);

    // Reset while the loader holds only the high byte.
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    begin
      bit ok;
      send_byte(8'hAB, 0, 1'b0, 1'b0, ok);
    end
    clear_log();
    in_valid = 1'b1;
    in_data  = 8'hCD;
    reset_n  = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    check_eq("midrst_idle_rdy", in_ready, 0);
    check_eq("midrst_nwrites", wd_q.size(), 0);
    in_valid = 1'b0;
    stim_b = '{8'h12, 8'h34, 8'hFF, 8'hFF};
    run_load("after_rst", 1'b1, 1'b0, 1'b0);

    for (int t = 0; t < 30; t++) begin
      stim_b.delete();
      for (int k = 0; k < DEPTH; k++) begin
        r = $urandom_range(0, 5);
        case (r)
          0:       w = 16'hFFFF;
          1:       w = 16'hFF00;
          2:       w = 16'h00FF;
          3:       w = 16'h7FFF;
          default: w = 16'($urandom);
        endcase
        push_word(w);
        if (w == 16'hFFFF) break;
      end
      run_load("rand", 1'($urandom_range(0, 1)), 1'b0, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
